// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: grants one of NREQ requesters a burst of up to
// BURST words into a FIFO, only when the FIFO has room for a whole burst.
module fifo_wr_arb #(
   parameter int DWID   = 32,
   parameter int AWID   = 10,
   parameter int NREQ   = 2,
   parameter int BURST  = 8,
   parameter int MARGIN = 4
) (
   input  logic                 wrclk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_vld,
   input  logic [NREQ*DWID-1:0] req_dat,
   output logic [NREQ-1:0]      req_rdy,
   input  logic [AWID-1:0]      fifo_wrlev,
   output logic                 fifo_wrena,
   output logic [DWID-1:0]      fifo_wrdat,
   output logic [NREQ-1:0]      grant,
   output logic [15:0]          stall_cnt
);

   localparam int LW = $clog2(NREQ);

   typedef enum logic {IDLE, BURST_ST} state_t;

   state_t          state, state_n;
   logic [NREQ-1:0] grant_n, pick_oh;
   logic [LW-1:0]   lptr, lptr_n, gidx;
   logic [5:0]      bcnt, bcnt_n;
   logic            wrena_n;
   logic [DWID-1:0] wrdat_n, gdat;
   logic [15:0]     stall_n;
   logic [AWID:0]   free;
   logic            space_ok, beat;

   // Space is only checked before a grant, so it must cover a full burst plus
   // the lag between our writes and the level we observe.
   assign free     = {1'b0, {AWID{1'b1}}} - {1'b0, fifo_wrlev};
   assign space_ok = int'(free) >= BURST + MARGIN;

   assign req_rdy = (rst && state == BURST_ST) ? grant : '0;
   assign beat    = (state == BURST_ST) && |(req_vld & grant);
   assign gdat    = req_dat[int'(gidx)*DWID +: DWID];

   // Round-robin search starting just after the last owner.
   always_comb begin : rr_pick
      int  j;
      logic found;
      pick_oh = '0;
      found   = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         j = int'(lptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_vld[j]) begin
            pick_oh[j] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   always_comb begin : grant_index
      gidx = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i]) gidx = LW'(i);
   end

   // NOTE: every next-state variable gets a default first so no latch is inferred.
   always_comb begin
      state_n = state;
      grant_n = grant;
      lptr_n  = lptr;
      bcnt_n  = bcnt;
      wrena_n = 1'b0;
      wrdat_n = fifo_wrdat;
      stall_n = stall_cnt;
      case (state)
         IDLE: begin
            if (|req_vld) begin
               if (space_ok) begin
                  state_n = BURST_ST;
                  grant_n = pick_oh;
                  bcnt_n  = '0;
               end else if (stall_cnt != 16'hFFFF) begin
                  stall_n = stall_cnt + 16'd1;
               end
            end
         end
         BURST_ST: begin
            if (beat) begin
               wrena_n = 1'b1;
               wrdat_n = gdat;
               bcnt_n  = bcnt + 6'd1;
            end
            // A dropped valid releases the port just like the final beat does.
            if (!beat || bcnt == 6'(BURST - 1)) begin
               state_n = IDLE;
               grant_n = '0;
               lptr_n  = gidx;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge wrclk) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         lptr       <= LW'(NREQ - 1);
         bcnt       <= '0;
         fifo_wrena <= 1'b0;
         fifo_wrdat <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         lptr       <= lptr_n;
         bcnt       <= bcnt_n;
         fifo_wrena <= wrena_n;
         fifo_wrdat <= wrdat_n;
         stall_cnt  <= stall_n;
      end
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter DWID, default 32, data width in bits of every requester and of the FIFO write port.
REQ-002 Parameter AWID, default 10, FIFO address width; usable capacity is 2**AWID-1 words.
REQ-003 Parameter NREQ, default 2, number of requesters; legal values 2..4.
REQ-004 Parameter BURST, default 8, maximum words per grant; legal values 1..64.
REQ-005 Parameter MARGIN, default 4, extra free words required beyond BURST, covering write-level lag.
REQ-006 wrclk  in  1  write clock; all logic is on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-low; clock wrclk.
REQ-008 req_vld  in  NREQ  per-requester data-valid.
REQ-009 req_dat  in  NREQ*DWID  per-requester data; requester i occupies bits [i*DWID +: DWID].
REQ-010 req_rdy  out  NREQ  per-requester ready; a beat is transferred when req_vld[i] and req_rdy[i] are both 1.
REQ-011 fifo_wrlev  in  AWID  FIFO write-side fill level.
REQ-012 fifo_wrena  out  1  FIFO write enable.
REQ-013 fifo_wrdat  out  DWID  FIFO write data.
REQ-014 grant  out  NREQ  one-hot current owner; all zero when no requester owns the port.
REQ-015 stall_cnt  out  16  saturating count of cycles blocked by insufficient FIFO space.

Function
REQ-016 The block SHALL have states IDLE and BURST, with a registered grant and a registered last-owner pointer lptr.
REQ-017 Free space SHALL be computed as (2**AWID-1) - fifo_wrlev, unsigned, at AWID+1 bits.
REQ-018 In IDLE, when any req_vld bit is 1 and free >= BURST+MARGIN, the block SHALL load a one-hot grant and enter BURST on the next edge.
REQ-019 Arbitration SHALL be round-robin: search starts at requester lptr+1 (mod NREQ) and picks the first requester whose req_vld bit is 1.
REQ-020 In IDLE, when any req_vld bit is 1 and free < BURST+MARGIN, the block SHALL stay in IDLE and increment stall_cnt, saturating at 16'hFFFF.
REQ-021 req_rdy[i] SHALL be combinational: 1 only when state is BURST and grant[i] is 1; all other bits 0.
REQ-022 In BURST, each handshake beat SHALL register fifo_wrena=1 and fifo_wrdat=the granted requester's data on the next edge; write latency is one cycle.
REQ-023 In any cycle without a beat, fifo_wrena SHALL be 0 on the next edge and fifo_wrdat SHALL hold its value.
REQ-024 A 6-bit beat counter SHALL clear on entry to BURST and increment on each beat.
REQ-025 The beat that brings the count to BURST SHALL end the burst: next state IDLE, grant cleared, lptr set to the granted index.
REQ-026 In BURST, if the granted requester's req_vld is 0, the burst SHALL end early that cycle with the same updates as REQ-025; no beat occurs in that cycle.
REQ-027 The block SHALL NOT issue more than BURST writes per grant.
REQ-028 The block SHALL NOT recheck free space in the middle of a burst.
REQ-029 After a burst ends, the earliest next grant SHALL be on the edge following the cycle spent in IDLE, giving a one-cycle gap between grants.
REQ-030 Requesters that are not granted SHALL see req_rdy 0 and SHALL NOT lose data.
REQ-031 Changes to req_vld from a non-granted requester during BURST SHALL have no effect.

Reset
REQ-032 While rst=0 at a rising edge of wrclk, the block SHALL set state IDLE, grant 0, lptr NREQ-1 (requester 0 first), beat counter 0, fifo_wrena 0, fifo_wrdat 0 and stall_cnt 0.
REQ-033 While rst=0, req_rdy SHALL be 0.
REQ-034 A reset asserted mid-burst SHALL abort the burst, and no write SHALL follow the reset edge.

Verification
REQ-035 Single requester: NREQ=2, BURST=8, fifo_wrlev=0, req_vld[0] held 1 with data 0..15 -> two bursts of 8 writes (data 0..7, then 8..15), fifo_wrena low for exactly one cycle between the bursts, grant=01.
REQ-036 Fairness: both requesters valid continuously -> grants alternate 01, 10, 01, ..., each for 8 writes, starting with requester 0 after reset.
REQ-037 Back-pressure: fifo_wrlev=1012 (free 11 < 12) with req_vld=01 -> no grant, stall_cnt increments every cycle; drop fifo_wrlev to 1011 -> grant on the next edge.
REQ-038 Early release: requester 1 drops valid after 3 beats -> exactly 3 writes, grant returns to 0, and requester 0 is granted next if valid.
REQ-039 Reset mid-burst: rst=0 after 4 beats -> next edge shows fifo_wrena 0, grant 0, stall_cnt 0; after release, requester 0 has priority.
REQ-040 Saturation: free space held insufficient for 70000 cycles with valid pending -> stall_cnt stops at 65535.
